// File: rtl/bcd_arb_pkg.sv
// Shared types and helpers for the BCD converter arbiter.
// The state enum and the BCD width rule are used by the interface, the top and the bench.
package bcd_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StAck   = 2'd2,
    StDrain = 2'd3
  } arb_state_e;

  // One BCD digit for every started group of three binary bits.
  function automatic int unsigned bcd_width(int unsigned w);
    return 4 * ((w + 2) / 3);
  endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Request/acknowledge and converter handshake bundle for bcd_conv_arbiter.
// slave is the arbiter's view; master is the requester/converter side.
interface bcd_conv_arbiter_if import bcd_arb_pkg::*; #(
  parameter int unsigned W    = 18,
  parameter int unsigned NREQ = 4,
  parameter int unsigned NB   = bcd_width(W)
);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] bin_in;
  logic [NREQ-1:0]   ack;
  logic [NB-1:0]     bcd_out;
  logic              busy;
  logic              conv_start;
  logic [W-1:0]      conv_binary;
  logic              conv_done;
  logic [NB-1:0]     conv_bcd;

  modport master (
    output req,
    output bin_in,
    output conv_done,
    output conv_bcd,
    input  ack,
    input  bcd_out,
    input  busy,
    input  conv_start,
    input  conv_binary
  );

  modport slave (
    input  req,
    input  bin_in,
    input  conv_done,
    input  conv_bcd,
    output ack,
    output bcd_out,
    output busy,
    output conv_start,
    output conv_binary
  );

endinterface

// File: rtl/bcd_conv_arbiter_rr_pick.sv
// Combinational winner picker: first set request searching upward from ptr, wrapping.
// With BCD_ARB_RR_EN undefined the pointer is ignored and the lowest index wins.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] ptr_eff;
  logic          found;
  int unsigned   pos;

`ifdef BCD_ARB_RR_EN
  assign ptr_eff = ptr;
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign ptr_eff    = '0;
`endif

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = (32'(ptr_eff) + i) % NREQ;
      if (!found && req[IW'(pos)]) begin
        found              = 1'b1;
        grant[IW'(pos)]    = 1'b1;
        idx                = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one binary-to-BCD converter between NREQ level requesters with a one-cycle ack.
// Define BCD_ARB_RR_EN for round-robin selection; otherwise fixed priority, lowest index wins.
module bcd_conv_arbiter import bcd_arb_pkg::*; #(
  parameter int unsigned W    = 18,
  parameter int unsigned NREQ = 4
) (
  input logic               clk,
  input logic               rst,
  bcd_conv_arbiter_if.slave bus
);

  localparam int unsigned NB = bcd_width(W);
  localparam int unsigned IW = $clog2(NREQ);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   grant_idx_q, grant_idx_d;
  logic [W-1:0]    bin_q, bin_d;
  logic [NB-1:0]   bcd_q, bcd_d;
  logic [IW-1:0]   ptr_q;
  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic [W-1:0]    bin_sel;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // One-hot AND-OR mux keeps the operand path shallow for any NREQ.
  always_comb begin
    bin_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        bin_sel = bin_sel | bus.bin_in[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    case (state_q)
      StIdle: begin
        if (|bus.req) begin
          grant_idx_d = pick_idx;
          bin_d       = bin_sel;
          state_d     = StRun;
        end
      end
      StRun: begin
        if (bus.conv_done) begin
          bcd_d   = bus.conv_bcd;
          state_d = StAck;
        end
      end
      StAck: begin
        state_d = StDrain;
      end
      StDrain: begin
        // Wait for the converter to release done so the next start is seen as fresh.
        if (!bus.conv_done) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_idx_q <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
    end
  end

`ifdef BCD_ARB_RR_EN
  logic [IW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StAck) begin
      ptr_d = (grant_idx_q == IW'(NREQ - 1)) ? '0 : grant_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign ptr_q = '0;
`endif

  always_comb begin
    bus.ack = '0;
    if (state_q == StAck) begin
      bus.ack[grant_idx_q] = 1'b1;
    end
  end

  assign bus.conv_start  = (state_q == StRun);
  assign bus.busy        = (state_q != StIdle);
  assign bus.bcd_out     = bcd_q;
  assign bus.conv_binary = bin_q;

  ack_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.ack));

endmodule
